// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment scanner.
package seven_seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         BCD_MAX    = 9;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Everything the display pins need for one slot, registered as a unit.
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic       blank;
    logic       err;
  } slot_out_t;

  localparam slot_out_t SLOT_DARK = '{an: AN_OFF, code: 4'h0, blank: 1'b1, err: 1'b0};

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: counts 0..CLK_DIV-1 and flags the last count of each slot.
module seg_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit BCD scan controller with shadow/active double buffering so a new
// value only ever appears from digit0 of a fresh frame.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic [3:0]  an,
  output logic        digit_blank,
  output logic        bcd_err,
  output logic        pending,
  output logic        frame_done
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic tick;

  seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  digit_idx_t                   idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]   active_q, active_d;
  logic                         pending_q, pending_d;
  logic                         frame_done_q, frame_done_d;
  slot_out_t                    out_q, out_d;
  logic                         frame_wrap;
  logic [NUM_DIGITS-1:0]        nib_zero;
  logic [NUM_DIGITS-1:0]        upper_zero;

  // upper_zero[i]: every nibble from i up to the most significant is zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign nib_zero[gi]   = (active_q[gi] == 4'h0);
      assign upper_zero[gi] = &nib_zero[NUM_DIGITS-1:gi];
    end
  endgenerate

  always_comb begin
    frame_wrap   = tick && (idx_q == LAST_IDX);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = frame_wrap;

    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end

    // A load landing on the wrap tick bypasses the shadow so it is not lost a frame.
    if (frame_wrap) begin
      if (load) begin
        active_d  = bcd_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  logic [3:0] cur_nib;
  logic       cur_err;
  logic       cur_lz;

  always_comb begin
    cur_nib = active_q[idx_q];
    cur_err = (cur_nib > 4'(BCD_MAX));
    cur_lz  = blank_lz && (idx_q != '0) && upper_zero[idx_q];

    out_d = SLOT_DARK;
    if (cur_lz || cur_err) begin
      out_d.err = cur_err;
    end else begin
      out_d.an    = ~(4'b0001 << idx_q);
      out_d.code  = cur_nib;
      out_d.blank = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      out_q        <= SLOT_DARK;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      out_q        <= out_d;
    end
  end

  assign an          = out_q.an;
  assign digit_code  = out_q.code;
  assign digit_blank = out_q.blank;
  assign bcd_err     = out_q.err;
  assign pending     = pending_q;
  assign frame_done  = frame_done_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range is 2 or more.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port load  in  1  single-cycle strobe capturing bcd_in.
REQ-005 SHALL have port bcd_in  in  16  four BCD nibbles; [3:0] is digit0 (least significant), [15:12] is digit3.
REQ-006 SHALL have port blank_lz  in  1  leading-zero blanking enable.
REQ-007 SHALL have port digit_code  out  4  BCD value of the scanned digit; feeds the 7-segment decoder input.
REQ-008 SHALL have port an  out  4  active-low one-hot anode select.
REQ-009 SHALL have port digit_blank  out  1  current slot is dark.
REQ-010 SHALL have port bcd_err  out  1  current slot nibble is greater than 9.
REQ-011 SHALL have port pending  out  1  captured value not yet displayed.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse at frame wrap.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick SHALL be asserted in the cycle where the count equals CLK_DIV-1.
REQ-014 Digit index idx SHALL advance 0→1→2→3→0 on each tick and hold otherwise.
REQ-015 load=1 SHALL write bcd_in to the shadow register and set pending=1 on the next edge; repeated loads before commit SHALL overwrite (last wins).
REQ-016 On a tick with idx=3 (frame boundary), if pending=1, the active register SHALL take the shadow value and pending SHALL clear; mid-frame updates are forbidden (no tearing).
REQ-017 If load and a frame-boundary tick coincide, active SHALL take bcd_in directly, shadow SHALL take bcd_in, and pending SHALL be 0.
REQ-018 frame_done SHALL be 1 for exactly the cycle after each frame-boundary tick.
REQ-019 Outputs SHALL be registered and reflect the new idx one cycle after idx changes.
REQ-020 For the displayed slot, an SHALL be the inverse of (1 << idx) and digit_code SHALL be active nibble[idx].
REQ-021 With blank_lz=1, slot idx (1..3) SHALL be blanked when nibbles idx..3 are all zero; digit0 is never blanked by this rule.
REQ-022 A nibble greater than 9 SHALL force blanking and set bcd_err=1 for that slot only.
REQ-023 A blanked slot SHALL drive an=4'b1111, digit_code=0, digit_blank=1; otherwise digit_blank=0.
REQ-024 Scan timing SHALL be independent of load activity.

Reset
REQ-025 When rst_n=0, regardless of clk, the block SHALL reset: prescaler=0, idx=0, shadow=0, active=0, pending=0, an=4'b1111, digit_code=0, digit_blank=1, bcd_err=0, frame_done=0.
REQ-026 After rst_n deasserts, the first slot (digit0, value 0) SHALL display after one clock; a mid-frame reset SHALL discard pending data.

Structure
REQ-027 Package seven_seg_pkg SHALL hold NUM_DIGITS=4, BCD_MAX=9 and AN_OFF=4'b1111.
REQ-028 The prescaler SHALL be the sub-module seg_tick_gen (parameter CLK_DIV; ports clk, rst_n, tick); all other logic stays in this module.

Verification (CLK_DIV=4)
REQ-029 Reset then free-run → an sequence 1110,1101,1011,0111 with each value held 4 cycles; frame_done pulses every 16 cycles.
REQ-030 load with bcd_in=16'h1234 mid-frame → pending=1; digit_code stays 0 until the frame wrap, then shows 4,3,2,1 and pending=0.
REQ-031 blank_lz=1 with bcd_in=16'h0070 → digits 3 and 2 are blanked (an=1111), digit1=7, digit0=0 shown; with blank_lz=0 all four are shown.
REQ-032 bcd_in=16'h00A5 → the digit1 slot has bcd_err=1 and digit_blank=1; other slots have bcd_err=0.
REQ-033 load of 16'h9999 on the frame-boundary tick cycle → the next frame shows 9999 and pending=0; two loads in one frame → only the second is shown.
REQ-034 rst_n pulsed low mid-frame with pending=1 → all outputs take reset values immediately and pending=0 afterwards.
